// File: rtl/title_axil_master.sv
// AXI4-Lite initiator: turns single-beat register commands into one outstanding AXI-Lite
// transaction at a time. Define TITLE_AXIL_TIMEOUT_EN to enable the watchdog abort.
module title_axil_master #(
    parameter int C_S00_AXI_ADDR_WIDTH = 4,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES       = 256
) (
    input  logic                                clk,
    input  logic                                reset,
    // command channel
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    // response channel
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic                                rsp_write,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                          rsp_resp,
    // AXI-Lite write address
    output logic [C_S00_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                          m_axi_awprot,
    output logic                                m_axi_awvalid,
    input  logic                                m_axi_awready,
    // AXI-Lite write data
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_S00_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                                m_axi_wvalid,
    input  logic                                m_axi_wready,
    // AXI-Lite write response
    input  logic [1:0]                          m_axi_bresp,
    input  logic                                m_axi_bvalid,
    output logic                                m_axi_bready,
    // AXI-Lite read address
    output logic [C_S00_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                          m_axi_arprot,
    output logic                                m_axi_arvalid,
    input  logic                                m_axi_arready,
    // AXI-Lite read data
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                          m_axi_rresp,
    input  logic                                m_axi_rvalid,
    output logic                                m_axi_rready
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrB,
        StRdA,
        StRdD,
        StResp
    } state_t;

    state_t state;
    logic   wd_expired;

    assign cmd_ready    = (state == StIdle);
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

`ifdef TITLE_AXIL_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    // IDLE keeps the response readies high to swallow late beats of an aborted transaction.
    localparam logic IdleReady = 1'b1;

    logic [CntW-1:0] wd_cnt;

    assign wd_expired = (wd_cnt == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || (state == StIdle)) begin
            wd_cnt <= '0;
        end else if ((state != StResp) && !wd_expired) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    localparam logic IdleReady = 1'b0;

    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
        end else if (wd_expired && (state != StIdle) && (state != StResp)) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b11;
            state         <= StResp;
        end else begin
            unique case (state)
                StIdle: begin
                    m_axi_bready <= IdleReady;
                    m_axi_rready <= IdleReady;
                    if (cmd_valid) begin
                        m_axi_bready <= 1'b0;
                        m_axi_rready <= 1'b0;
                        rsp_write    <= cmd_write;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= StWr;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= StRdA;
                        end
                    end
                end
                StWr: begin
                    // AW and W retire independently; a lowered valid means that side is done.
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= StWrB;
                    end
                end
                StWrB: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                        state        <= StResp;
                    end
                end
                StRdA: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= StRdD;
                    end
                end
                StRdD: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        state        <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        m_axi_bready <= IdleReady;
                        m_axi_rready <= IdleReady;
                        state        <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
